// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter pushing requester beats into a downstream FIFO (optional stats: FIFO_PUSH_ARBITER_STATS_EN)
module fifo_push_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN = 4,
  localparam int IDX_WIDTH = $clog2(NUM_IN)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_IN-1:0]                    valid_i,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    data_i,
  output logic [NUM_IN-1:0]                    ready_o,
  input  logic                                 fifo_full_i,
  output logic                                 fifo_push_o,
  output logic [DATA_WIDTH-1:0]                fifo_data_o,
  output logic                                 fifo_flush_o,
  output logic [IDX_WIDTH-1:0]                 gnt_idx_o,
  output logic                                 busy_o,
  output logic [NUM_IN-1:0][15:0]              stat_cnt_o
);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, BURST} state_e;
  state_e state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel, gnt;
  logic [BW-1:0] beat_q, beat_d;
  logic acc;

  function automatic logic [IDX_WIDTH-1:0] nxt(input logic [IDX_WIDTH-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + IDX_WIDTH'(1);
  endfunction

  // first valid requester at or after rr_ptr, wrapping; falls back to rr_ptr
  always_comb begin
    sel = rr_ptr_q;
    for (int k = NUM_IN - 1; k >= 0; k--)
      if (valid_i[(int'(rr_ptr_q) + k) % NUM_IN]) sel = IDX_WIDTH'((int'(rr_ptr_q) + k) % NUM_IN);
  end

  assign gnt          = !rst_ni ? '0 : (state_q == BURST ? owner_q : sel);
  assign acc          = rst_ni && !flush_i && !fifo_full_i && valid_i[gnt];
  assign ready_o      = acc ? (NUM_IN'(1) << gnt) : '0;
  assign fifo_push_o  = |(valid_i & ready_o);
  assign fifo_data_o  = data_i[gnt];
  assign fifo_flush_o = flush_i;
  assign gnt_idx_o    = gnt;
  assign busy_o       = state_q == BURST;

  // burst sequencing: flush clears, full freezes, a missing owner beat or a full burst ends the grant
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    if (flush_i) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
      owner_d  = '0;
      beat_d   = '0;
    end else if (!fifo_full_i) begin
      if (state_q == IDLE) begin
        if (acc && BURST_LEN > 1) begin
          state_d = BURST;
          owner_d = gnt;
          beat_d  = BW'(1);
        end else if (acc) rr_ptr_d = nxt(gnt);
      end else if (!acc || beat_q + BW'(1) == BW'(BURST_LEN)) begin
        state_d  = IDLE;
        rr_ptr_d = nxt(owner_q);
        beat_d   = '0;
      end else beat_d = beat_q + BW'(1);
    end
  end

  // arbiter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [NUM_IN-1:0][15:0] stat_q, stat_d;

  // saturating per-requester accepted-beat counters, kept across flush
  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      stat_d[i] = (valid_i[i] && ready_o[i] && stat_q[i] != 16'hFFFF) ? stat_q[i] + 16'd1 : stat_q[i];
  end

  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stat_q <= '0;
    else stat_q <= stat_d;
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: table-driven check of grant/push/burst behaviour plus reset and stats sequences
module tb_fifo_push_arbiter;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [3:0]        valid;
  logic [3:0][31:0]  data;
  logic [3:0]        ready;
  logic              full;
  logic              push;
  logic [31:0]       fdata;
  logic              fflush;
  logic [1:0]        gnt;
  logic              busy;
  logic [3:0][15:0]  stat;

  typedef struct {
    logic       flush;
    logic       full;
    logic [3:0] valid;
    logic       push;
    logic [1:0] gnt;
    logic [3:0] ready;
    logic       busy;
  } vec_t;

  vec_t tbl[64];
  int n = 0;
  int checks = 0;
  int errors = 0;
  int cnt[4] = '{0, 0, 0, 0};

  fifo_push_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .BURST_LEN(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .data_i(data),
    .ready_o(ready), .fifo_full_i(full), .fifo_push_o(push), .fifo_data_o(fdata),
    .fifo_flush_o(fflush), .gnt_idx_o(gnt), .busy_o(busy), .stat_cnt_o(stat)
  );

  always #5 clk = ~clk;

  task automatic add(input logic fl, input logic fu, input logic [3:0] v, input logic p,
                     input logic [1:0] g, input logic [3:0] r, input logic b);
    tbl[n] = '{fl, fu, v, p, g, r, b};
    n++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    for (int c = 0; c < 16; c++) add(0, 0, 4'hF, 1, 2'(c / 4), 4'(1 << (c / 4)), c % 4 != 0);
    add(0, 0, 4'hF, 1, 0, 4'b0001, 0);
    add(1, 0, 4'hF, 0, 0, 4'b0000, 1);
    for (int c = 0; c < 8; c++) add(0, 0, 4'b0100, 1, 2, 4'b0100, c % 4 != 0);
    add(0, 0, 4'b0010, 1, 1, 4'b0010, 0);
    add(0, 0, 4'b1010, 1, 1, 4'b0010, 1);
    add(0, 0, 4'b1000, 0, 1, 4'b0000, 1);
    add(0, 0, 4'b1000, 1, 3, 4'b1000, 0);
    add(0, 0, 4'b1000, 1, 3, 4'b1000, 1);
    for (int c = 0; c < 3; c++) add(0, 1, 4'b1000, 0, 3, 4'b0000, 1);
    add(0, 0, 4'b1000, 1, 3, 4'b1000, 1);
    add(0, 0, 4'b1000, 1, 3, 4'b1000, 1);
    add(0, 0, 4'b1000, 1, 3, 4'b1000, 0);
    add(0, 0, 4'b0000, 0, 3, 4'b0000, 1);
    add(0, 0, 4'b0100, 1, 2, 4'b0100, 0);
    add(0, 0, 4'b0100, 1, 2, 4'b0100, 1);
    add(1, 0, 4'b0101, 0, 2, 4'b0000, 1);
    add(0, 0, 4'b0101, 1, 0, 4'b0001, 0);
    add(0, 1, 4'b0101, 0, 0, 4'b0000, 1);

    for (int i = 0; i < 4; i++) data[i] = 32'hA0 + i;
    rst_n = 1'b0; flush = 1'b0; full = 1'b0; valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_push", -1, 32'(push), 0);
    chk("rst_busy", -1, 32'(busy), 0);
    chk("rst_gnt", -1, 32'(gnt), 0);
    chk("rst_stat", -1, 32'(|stat), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      flush = tbl[i].flush; full = tbl[i].full; valid = tbl[i].valid;
      #1;
      chk("push", i, 32'(push), 32'(tbl[i].push));
      chk("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
      chk("ready", i, 32'(ready), 32'(tbl[i].ready));
      chk("busy", i, 32'(busy), 32'(tbl[i].busy));
      chk("data", i, fdata, 32'hA0 + 32'(tbl[i].gnt));
      chk("flush_o", i, 32'(fflush), 32'(tbl[i].flush));
      if (tbl[i].push) cnt[tbl[i].gnt]++;
      @(negedge clk);
    end

    #1;
    for (int i = 0; i < 4; i++)
`ifdef FIFO_PUSH_ARBITER_STATS_EN
      chk("stat_tbl", i, 32'(stat[i]), 32'(cnt[i]));
`else
      chk("stat_tbl", i, 32'(stat[i]), 0);
`endif

    full = 1'b0; flush = 1'b0; valid = 4'hF;
    chk("pre_rst_busy", 0, 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 0, 32'(busy), 0);
    chk("midrst_push", 0, 32'(push), 0);
    chk("midrst_gnt", 0, 32'(gnt), 0);
    chk("midrst_stat", 0, 32'(|stat), 0);

    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0001;
    #1;
    chk("post_rst_gnt", 0, 32'(gnt), 0);
    chk("post_rst_push", 0, 32'(push), 1);
    chk("post_rst_busy", 0, 32'(busy), 0);

    for (int c = 0; c < 70000; c++) @(negedge clk);
    #1;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    chk("stat_sat0", 0, 32'(stat[0]), 32'hFFFF);
`else
    chk("stat_sat0", 0, 32'(stat[0]), 0);
`endif
    chk("stat_sat1", 1, 32'(stat[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of requesters; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 32, payload width.
REQ-003 Parameter BURST_LEN, default 4, max consecutive beats per grant; SHALL be >= 1.
REQ-004 Derived IDX_WIDTH SHALL be $clog2(NUM_IN) and is not user-overridable.
REQ-005 clk_i  input  1  single clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous reset, active-low.
REQ-007 flush_i  input  1  synchronous flush of arbiter and downstream FIFO.
REQ-008 valid_i  input  NUM_IN  per-requester data valid.
REQ-009 data_i  input  NUM_IN x DATA_WIDTH  per-requester payload.
REQ-010 ready_o  output  NUM_IN  per-requester accept; a beat transfers when valid_i[i] & ready_o[i].
REQ-011 fifo_full_i  input  1  downstream FIFO full flag.
REQ-012 fifo_push_o  output  1  push strobe to downstream FIFO.
REQ-013 fifo_data_o  output  DATA_WIDTH  payload to downstream FIFO.
REQ-014 fifo_flush_o  output  1  flush to downstream FIFO.
REQ-015 gnt_idx_o  output  IDX_WIDTH  index of the currently selected requester.
REQ-016 busy_o  output  1  high while in BURST state.
REQ-017 stat_cnt_o  output  NUM_IN x 16  per-requester accepted-beat counters.

Function
REQ-018 The FSM SHALL have two states, IDLE and BURST, plus registers rr_ptr (IDX_WIDTH), owner (IDX_WIDTH) and beat_cnt ($clog2(BURST_LEN+1) bits).
REQ-019 In IDLE, selection SHALL be the first asserted valid_i, searching from index rr_ptr upward with wrap modulo NUM_IN; with no valid, gnt_idx_o = rr_ptr.
REQ-020 In IDLE with a selected requester and fifo_full_i low, the beat SHALL be accepted the same cycle (zero latency: ready_o[sel]=1, fifo_push_o=1).
REQ-021 On an IDLE accept with BURST_LEN > 1, the FSM SHALL go to BURST with owner=sel and beat_cnt=1; with BURST_LEN == 1 it stays IDLE and rr_ptr becomes (sel+1) mod NUM_IN.
REQ-022 In BURST, only owner SHALL be granted: gnt_idx_o = owner, and every other ready_o SHALL be 0.
REQ-023 In BURST, an owner beat with fifo_full_i low SHALL be accepted and SHALL increment beat_cnt; when the incremented beat_cnt equals BURST_LEN, the next state SHALL be IDLE with rr_ptr = (owner+1) mod NUM_IN.
REQ-024 In BURST with valid_i[owner] low, there SHALL be no push that cycle, and the next state SHALL be IDLE with rr_ptr = (owner+1) mod NUM_IN.
REQ-025 fifo_full_i high SHALL force all ready_o=0 and fifo_push_o=0, and SHALL freeze state, owner, beat_cnt and rr_ptr (no timeout).
REQ-026 fifo_push_o SHALL equal the OR of (valid_i & ready_o), and at most one ready_o bit SHALL be high per cycle.
REQ-027 fifo_data_o SHALL equal data_i[gnt_idx_o] in every cycle.
REQ-028 fifo_flush_o SHALL equal flush_i combinationally.
REQ-029 While flush_i is high, all ready_o and fifo_push_o SHALL be 0, and the next state SHALL be IDLE with rr_ptr=0, owner=0, beat_cnt=0; stat_cnt_o is retained.
REQ-030 ready_o MAY depend combinationally on valid_i, and valid_i SHALL NOT depend on ready_o.

Reset
REQ-031 Asynchronous reset assertion SHALL force IDLE, rr_ptr=0, owner=0, beat_cnt=0 and stat counters=0, including mid-burst.
REQ-032 During reset, fifo_push_o=0, busy_o=0, gnt_idx_o=0 and stat_cnt_o=0 SHALL hold; ready_o follows REQ-019/020 after release.

Configuration
REQ-033 With macro FIFO_PUSH_ARBITER_STATS_EN defined, each stat_cnt_o[i] SHALL increment on every accepted beat of requester i and saturate at 0xFFFF.
REQ-034 Without FIFO_PUSH_ARBITER_STATS_EN, stat_cnt_o SHALL be tied to 0, no counter flops SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-035 NUM_IN=4, BURST_LEN=4, all valid constantly, full low -> 16 pushes in 16 cycles with gnt_idx sequence 0x4, 1x4, 2x4, 3x4, then 0.
REQ-036 Only valid_i[2] high for 8 cycles -> 8 consecutive pushes, all from index 2, no bubble at the burst boundary.
REQ-037 Owner 1 drops valid after 2 beats while valid_i[3] is high -> one cycle with no push, then idx 3 granted (rr_ptr=2).
REQ-038 fifo_full_i high for 3 cycles after beat 2 of a burst -> ready_o=0 and no push for 3 cycles, then 2 more beats from the same owner, then IDLE.
REQ-039 flush_i pulsed mid-burst of owner 2 -> fifo_flush_o high that cycle with push 0; next cycle IDLE and idx 0 wins if valid.
REQ-040 70000 beats from requester 0 -> stat_cnt_o[0]=0xFFFF with FIFO_PUSH_ARBITER_STATS_EN defined, 0 without it.
